hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the five-stage core. It drives the PC, IF/ID and ID/EX pipeline-register control lines. It detects load-use hazards against the ID/EX stage, squashes wrong-path instructions on a taken branch, and holds a multiply/divide instruction in ID for a fixed number of cycles while the iterative unit runs. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 73 +++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, taken-branch and iterative muldiv hazard control for the
// five-stage pipeline, with a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             id_muldiv_i,
  input  logic             exe_mem_read_i,
  input  logic [4:0]       exe_num_write_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_exe_flush_o,
  output logic             md_start_o,
  output logic             md_abort_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_cycles_o
);
  typedef enum logic {RUN, MD_WAIT} state_e;
  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use, stall, br;
  assign load_use = exe_mem_read_i && exe_num_write_i != 5'd0 &&
                    ((id_uses_rs_i && exe_num_write_i == id_rs_i) ||
                     (id_uses_rt_i && exe_num_write_i == id_rt_i));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (br) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (md_start_o) begin
      state_d = MD_WAIT;
      cnt_d   = 8'(MULDIV_CYCLES - 1);
    end else if (state_q == MD_WAIT) begin
      state_d = cnt_q != 8'd0 ? MD_WAIT : RUN;
      cnt_d   = cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q;
    end
    stall_d = (!pc_write_o && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
  end
  // A release cycle (MD_WAIT, cnt==0) ignores id_muldiv, so no restart is possible there.
  always_comb begin
    br             = rst_ni && branch_taken_i;
    stall          = rst_ni && !br && (state_q == RUN ? (load_use || id_muldiv_i) : cnt_q != 8'd0);
    pc_write_o     = rst_ni && !stall;
    if_id_write_o  = pc_write_o;
    if_id_flush_o  = br;
    id_exe_flush_o = br || stall;
    md_start_o     = stall && state_q == RUN && !load_use;
    md_abort_o     = br && state_q == MD_WAIT;
  end
  assign md_busy_o      = state_q == MD_WAIT;
  assign stall_cycles_o = stall_q;
endmodule
